// File: rtl/shared_resource_responder.sv
// Two-client responder: round-robin arbitration into a fixed-latency +INC unit,
// with per-client credit counters and in-order result FIFOs.
module shared_resource_responder #(
  parameter int unsigned       DATA_W = 32,
  parameter int unsigned       LAT    = 3,
  parameter int unsigned       DEPTH  = 4,
  parameter logic [DATA_W-1:0] INC    = DATA_W'(1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic [DATA_W-1:0] in_data_2,
  input  logic              in_valid_1,
  input  logic              in_valid_2,
  input  logic              in_flush_1,
  input  logic              in_flush_2,
  input  logic              in_stall_1,
  input  logic              in_stall_2,
  output logic [DATA_W-1:0] out_data_1,
  output logic [DATA_W-1:0] out_data_2,
  output logic              out_valid_1,
  output logic              out_valid_2,
  output logic              out_stall_1,
  output logic              out_stall_2,
  output logic              out_flush_1,
  output logic              out_flush_2
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef struct packed {
    logic              vld;
    logic              tag;
    logic [DATA_W-1:0] data;
  } fu_t;

  logic [1:0]        in_valid, in_flush, in_stall;
  logic [1:0]        out_valid_c, pop, push, elig, ve, grant, stall_c;
  logic [1:0]        flush_q;
  logic              last2_q;
  logic [CW-1:0]     cnt_q    [2];
  logic [CW-1:0]     cnt_d    [2];
  logic [CW-1:0]     credit_q [2];
  logic [CW-1:0]     credit_d [2];
  logic [PW-1:0]     rd_q     [2];
  logic [PW-1:0]     wr_q     [2];
  logic [DATA_W-1:0] mem_q    [2][DEPTH];
  fu_t               stage_q  [LAT];
  fu_t               stage_d  [LAT];

  assign in_valid = {in_valid_2, in_valid_1};
  assign in_flush = {in_flush_2, in_flush_1};
  assign in_stall = {in_stall_2, in_stall_1};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Eligibility, arbitration, counter next-state and FU shift
  always_comb begin
    out_valid_c = '0;
    pop         = '0;
    push        = '0;
    elig        = '0;
    for (int c = 0; c < 2; c++) begin
      out_valid_c[1'(c)] = reset & (cnt_q[1'(c)] != '0);
      pop[1'(c)]         = out_valid_c[1'(c)] & ~in_stall[1'(c)];
      elig[1'(c)]        = ~in_flush[1'(c)] &
                           ((credit_q[1'(c)] - CW'(pop[1'(c)])) < CW'(DEPTH));
      push[1'(c)]        = stage_q[SW'(LAT-1)].vld &
                           (stage_q[SW'(LAT-1)].tag == 1'(c));
    end
    ve       = in_valid & elig;
    grant[0] = reset & ve[0] & (~ve[1] | last2_q);
    grant[1] = reset & ve[1] & ~grant[0];
    // A valid request loses only when the other client is granted on a tie
    stall_c[0] = ~reset | ~elig[0] | (in_valid[0] & ve[1] & ~last2_q);
    stall_c[1] = ~reset | ~elig[1] | (in_valid[1] & ve[0] & last2_q);
    for (int c = 0; c < 2; c++) begin
      cnt_d[1'(c)]    = cnt_q[1'(c)] + CW'(push[1'(c)]) - CW'(pop[1'(c)]);
      credit_d[1'(c)] = credit_q[1'(c)] + CW'(grant[1'(c)]) - CW'(pop[1'(c)]);
    end
    stage_d[0].vld  = |grant;
    stage_d[0].tag  = grant[1];
    stage_d[0].data = (grant[1] ? in_data_2 : in_data_1) + INC;
    for (int i = 1; i < LAT; i++) begin
      stage_d[SW'(i)]     = stage_q[SW'(i-1)];
      stage_d[SW'(i)].vld = stage_q[SW'(i-1)].vld & ~in_flush[stage_q[SW'(i-1)].tag];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < LAT; i++) stage_q[SW'(i)] <= '0;
      for (int c = 0; c < 2; c++) begin
        cnt_q[1'(c)]    <= '0;
        credit_q[1'(c)] <= '0;
        rd_q[1'(c)]     <= '0;
        wr_q[1'(c)]     <= '0;
      end
      last2_q <= 1'b1;
      flush_q <= '0;
    end else begin
      for (int i = 0; i < LAT; i++) stage_q[SW'(i)] <= stage_d[SW'(i)];
      flush_q <= in_flush;
      if (|grant) last2_q <= grant[1];
      for (int c = 0; c < 2; c++) begin
        if (in_flush[1'(c)]) begin
          cnt_q[1'(c)]    <= '0;
          credit_q[1'(c)] <= '0;
          rd_q[1'(c)]     <= '0;
          wr_q[1'(c)]     <= '0;
        end else begin
          if (push[1'(c)]) begin
            mem_q[1'(c)][wr_q[1'(c)]] <= stage_q[SW'(LAT-1)].data;
            wr_q[1'(c)]               <= ptr_inc(wr_q[1'(c)]);
          end
          if (pop[1'(c)]) rd_q[1'(c)] <= ptr_inc(rd_q[1'(c)]);
          cnt_q[1'(c)]    <= cnt_d[1'(c)];
          credit_q[1'(c)] <= credit_d[1'(c)];
        end
      end
    end
  end

  assign out_valid_1 = out_valid_c[0];
  assign out_valid_2 = out_valid_c[1];
  assign out_data_1  = out_valid_c[0] ? mem_q[0][rd_q[0]] : '0;
  assign out_data_2  = out_valid_c[1] ? mem_q[1][rd_q[1]] : '0;
  assign out_stall_1 = stall_c[0];
  assign out_stall_2 = stall_c[1];
  assign out_flush_1 = reset & flush_q[0];
  assign out_flush_2 = reset & flush_q[1];

endmodule

// File: tb/tb_shared_resource_responder.sv
// Randomized bench for shared_resource_responder against a queue-based
// transaction model (timestamps for FU latency, per-client result queues).
module tb_shared_resource_responder;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LAT    = 3;
  localparam int unsigned DEPTH  = 4;
  localparam int          NCYC   = 1800;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] in_data_1, in_data_2;
  logic        in_valid_1, in_valid_2, in_flush_1, in_flush_2, in_stall_1, in_stall_2;
  logic [31:0] out_data_1, out_data_2;
  logic        out_valid_1, out_valid_2, out_stall_1, out_stall_2, out_flush_1, out_flush_2;

  shared_resource_responder #(.DATA_W(DATA_W), .LAT(LAT), .DEPTH(DEPTH), .INC(32'h1)) dut (
    .clk(clk), .reset(reset),
    .in_data_1(in_data_1), .in_data_2(in_data_2),
    .in_valid_1(in_valid_1), .in_valid_2(in_valid_2),
    .in_flush_1(in_flush_1), .in_flush_2(in_flush_2),
    .in_stall_1(in_stall_1), .in_stall_2(in_stall_2),
    .out_data_1(out_data_1), .out_data_2(out_data_2),
    .out_valid_1(out_valid_1), .out_valid_2(out_valid_2),
    .out_stall_1(out_stall_1), .out_stall_2(out_stall_2),
    .out_flush_1(out_flush_1), .out_flush_2(out_flush_2)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
    end
  endtask

  // Model: accepted requests wait in 'infl' until their due cycle, then join rq[c]
  typedef struct { int c; logic [31:0] d; int t; } inflt_t;
  inflt_t      infl[$];
  logic [31:0] rq[2][$];
  int          credit[2];
  int          last_g;
  bit          fl_prev[2];

  initial begin
    bit          v[2], st[2], fl[2], rst, ev[2], pop[2], elig[2], ve[2];
    logic [31:0] dat[2], ed[2];
    int          pv, ps, pf, pr, pff, g, phase;
    inflt_t      keep[$];

    credit[0] = 0; credit[1] = 0; last_g = 1; fl_prev[0] = 0; fl_prev[1] = 0;
    reset = 1'b0;
    in_data_1 = '0; in_data_2 = '0; in_valid_1 = 0; in_valid_2 = 0;
    in_flush_1 = 0; in_flush_2 = 0; in_stall_1 = 0; in_stall_2 = 0;

    for (int n = 0; n < NCYC; n++) begin
      cyc = n;
      @(negedge clk);
      phase = n / 300;
      case (phase)
        0:       begin pv = 90;  ps = 0;  pf = 0;  pr = 0;  pff = 12; end
        1:       begin pv = 70;  ps = 60; pf = 0;  pr = 0;  pff = 12; end
        2:       begin pv = 100; ps = 0;  pf = 0;  pr = 0;  pff = 12; end
        3:       begin pv = 60;  ps = 30; pf = 40; pr = 0;  pff = 12; end
        4:       begin pv = 70;  ps = 30; pf = 10; pr = 15; pff = 12; end
        default: begin pv = 50;  ps = 20; pf = 5;  pr = 5;  pff = 50; end
      endcase
      rst = !(n < 2 || $urandom_range(999) < pr);
      for (int c = 0; c < 2; c++) begin
        v[c]   = $urandom_range(99) < pv;
        st[c]  = $urandom_range(99) < ps;
        fl[c]  = $urandom_range(999) < pf;
        dat[c] = ($urandom_range(99) < pff) ? 32'hFFFF_FFFF : $urandom;
      end
      if (phase == 2) begin
        st[0] = (n % 40) < 20;
        v[1]  = $urandom_range(99) < 30;
      end
      reset = rst;
      in_valid_1 = v[0]; in_valid_2 = v[1];
      in_stall_1 = st[0]; in_stall_2 = st[1];
      in_flush_1 = fl[0]; in_flush_2 = fl[1];
      in_data_1 = dat[0]; in_data_2 = dat[1];
      #1;

      // Expected outputs for this cycle
      for (int c = 0; c < 2; c++) begin
        ev[c]   = rst && rq[c].size() > 0;
        ed[c]   = ev[c] ? rq[c][0] : 32'h0;
        pop[c]  = ev[c] && !st[c];
        elig[c] = !fl[c] && (credit[c] - int'(pop[c])) < int'(DEPTH);
        ve[c]   = v[c] && elig[c];
      end
      g = -1;
      if (rst) begin
        if (ve[0] && ve[1]) g = (last_g == 0) ? 1 : 0;
        else if (ve[0])     g = 0;
        else if (ve[1])     g = 1;
      end
      check_eq("valid1", 32'(out_valid_1), 32'(ev[0]));
      check_eq("valid2", 32'(out_valid_2), 32'(ev[1]));
      check_eq("data1",  out_data_1, ed[0]);
      check_eq("data2",  out_data_2, ed[1]);
      check_eq("flush1", 32'(out_flush_1), 32'(rst && fl_prev[0]));
      check_eq("flush2", 32'(out_flush_2), 32'(rst && fl_prev[1]));
      check_eq("stall1", 32'(out_stall_1), 32'(!rst || !elig[0] || (v[0] && g == 1)));
      check_eq("stall2", 32'(out_stall_2), 32'(!rst || !elig[1] || (v[1] && g == 0)));

      // Advance model across the rising edge
      if (!rst) begin
        infl.delete();
        rq[0].delete(); rq[1].delete();
        credit[0] = 0; credit[1] = 0; last_g = 1;
        fl_prev[0] = 0; fl_prev[1] = 0;
      end else begin
        for (int c = 0; c < 2; c++) begin
          fl_prev[c] = fl[c];
          if (fl[c]) begin
            rq[c].delete();
            credit[c] = 0;
          end else if (pop[c]) begin
            void'(rq[c].pop_front());
            credit[c]--;
          end
        end
        keep.delete();
        foreach (infl[i]) begin
          if (fl[infl[i].c]) continue;
          if (infl[i].t == n) rq[infl[i].c].push_back(infl[i].d);
          else keep.push_back(infl[i]);
        end
        infl = keep;
        if (g >= 0) begin
          credit[g]++;
          infl.push_back('{c: g, d: dat[g] + 32'h1, t: n + int'(LAT)});
          last_g = g;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/shared_resource_responder.md
# shared_resource_responder

Responder end of the pipeline-to-shared-resource request/response interface used by the dual-pipeline wrapper. Accepts requests from two client pipelines on independent data/valid/flush/stall channels, arbitrates them round-robin into one fixed-latency function unit, and returns each result to its originating client in order. Per-client credit counters and result FIFOs guarantee that no result is dropped when a client stalls.

## Interface

- DATA_W, 32, request/result data width
- LAT, 3, function-unit pipeline depth in cycles (≥1)
- DEPTH, 4, per-client result FIFO depth and credit limit (≥LAT+1 for full throughput)
- INC, 32'h1, constant added by the function unit
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- in_data_1 / in_data_2  input  DATA_W  request operand from client 1 / 2
- in_valid_1 / in_valid_2  input  1  request present
- in_flush_1 / in_flush_2  input  1  kill all outstanding work of that client
- in_stall_1 / in_stall_2  input  1  client cannot take a result this cycle
- out_data_1 / out_data_2  output  DATA_W  result to client
- out_valid_1 / out_valid_2  output  1  result present
- out_stall_1 / out_stall_2  output  1  request not accepted this cycle
- out_flush_1 / out_flush_2  output  1  flush-complete pulse

## Operation

- Result = (in_data + INC) mod 2^DATA_W; no saturation, carry discarded.
- Request accept for client x: in_valid_x & ~out_stall_x. At most one accept per cycle (single FU port).
- Eligibility of x: ~in_flush_x and (credit_x − pop_x) < DEPTH, where pop_x = out_valid_x & ~in_stall_x.
- Arbitration: if both valid and eligible, grant the client not granted last; last_grant register resets to client 2, so client 1 wins the first tie. last_grant updates only on an actual accept.
- out_stall_x = 1 if x is ineligible or loses arbitration; otherwise 0. Combinational from in_valid_*, in_flush_*, in_stall_*, and state.
- FU: LAT-stage shift register of {valid, client tag, data}; never stalls. Stage LAT pushes into result FIFO of its tag.
- credit_x: +1 on accept, −1 on pop, unchanged when both occur; range 0..DEPTH.
- Result FIFO x: in-order; push and pop in the same cycle both take effect; full cannot occur because of credits. out_valid_x = FIFO non-empty; out_data_x = head, forced to 0 when empty.
- Flush x (in_flush_x=1): same edge clears FIFO x, invalidates every FU stage tagged x, sets credit_x to 0; any request from x that cycle is dropped, and any pop that cycle is ignored (flush wins). Client y state is untouched. out_flush_x = 1 for exactly the next cycle.

## Timing

- Reset (reset=0 at an edge): FIFOs emptied, FU stages invalid, credits 0, last_grant=2. While reset is low: out_valid_*=0, out_data_*=0, out_flush_*=0, out_stall_*=1. After reset rises: out_stall_* follow the rules above from the first cycle.
- Latency: request accepted in cycle t → out_valid_x high from cycle t+LAT+1 (cycle 4 for LAT=3).
- Throughput: one accept per cycle total; single client streams at 1/cycle with in_stall=0 and DEPTH≥LAT+1; two clients alternate.
- Result held stable on out_data_x while in_stall_x=1.
- Reset mid-operation discards all in-flight and buffered results; nothing stale appears after reset.

## Test plan

- Client 1 sends 0x10 at cycle 0, in_stall_1=0 → out_valid_1=1 with out_data_1=0x11 at cycle 4 only; client 2 outputs stay 0.
- Both valid at cycle 0 (0x5, 0x7) → cycle 0: out_stall_1=0, out_stall_2=1; cycle 1: client 2 accepted; out_data_1=0x6 at cycle 4, out_data_2=0x8 at cycle 5.
- in_stall_1=1, client 1 offers 6 back-to-back requests 1..6 → exactly 4 accepted, then out_stall_1 held 1; release stall → results 2,3,4,5 in order, then remaining requests accepted.
- Request 0xFFFFFFFF → result 0x00000000.
- Client 1 has 2 in flight, client 2 has 1; assert in_flush_1 one cycle → out_flush_1 pulses next cycle, no client 1 results ever emerge, client 2 result delivered unchanged, client 1 can then have 4 new requests accepted.
- Reset low for one cycle with results buffered and in flight → outputs zero, out_stall_*=1 during reset; no out_valid after release until new requests.
